traffic_light_checker: RTL and testbench

- Passive protocol monitor on the light outputs of the traffic_light controller; the receiving end of its six lamp signals.
- Decodes lamp patterns into phases, tracks the NS_G -> NS_Y -> EW_G -> EW_Y sequence and per-phase tick durations, and flags any violation.
- Instantiated beside the controller in benches and on-chip as a safety watchdog. Shares clk, rst and tick with the controller.

---
 rtl/traffic_light_checker.sv | 216 +++++++++++++++++++++
 tb/tb_traffic_light_checker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_checker.sv
// traffic_light_checker
//   Passive monitor on the six lamp outputs of the traffic_light controller.
//   Decodes lamp patterns into phases, follows NS_G -> NS_Y -> EW_G -> EW_Y,
//   checks per-phase tick durations and flags any violation.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   tick                1-cycle timebase pulse shared with the controller
//   ns_g/ns_y/ns_r      north-south lamps
//   ew_g/ew_y/ew_r      east-west lamps
//   phase               last legal phase (0=NS_G 1=NS_Y 2=EW_G 3=EW_Y)
//   locked              synchronised to a verified-correct sequence
//   err_onehot          pulse: a direction's lamps are not exactly one-hot
//   err_conflict        pulse: neither direction shows red
//   err_seq             pulse: illegal phase transition
//   err_dur             pulse: phase too short or too long
//   err_any             sticky OR of all error pulses, cleared only by rst
//   cycle_count         completed correct full cycles, saturating
module traffic_light_checker #(
  parameter int unsigned G_TICKS = 5,
  parameter int unsigned Y_TICKS = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             ns_g,
  input  logic             ns_y,
  input  logic             ns_r,
  input  logic             ew_g,
  input  logic             ew_y,
  input  logic             ew_r,
  output logic [1:0]       phase,
  output logic             locked,
  output logic             err_onehot,
  output logic             err_conflict,
  output logic             err_seq,
  output logic             err_dur,
  output logic             err_any,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned MAX_T = (G_TICKS > Y_TICKS) ? G_TICKS : Y_TICKS;
  localparam int unsigned TW    = $clog2(MAX_T + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_TRACK
  } state_t;

  typedef enum logic [1:0] {
    PH_NS_G = 2'd0,
    PH_NS_Y = 2'd1,
    PH_EW_G = 2'd2,
    PH_EW_Y = 2'd3
  } phase_t;

  function automatic logic [TW-1:0] exp_ticks(input phase_t p);
    return ((p == PH_NS_G) || (p == PH_EW_G)) ? TW'(G_TICKS) : TW'(Y_TICKS);
  endfunction

  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    case (p)
      PH_NS_G: n = PH_NS_Y;
      PH_NS_Y: n = PH_EW_G;
      PH_EW_G: n = PH_EW_Y;
      default: n = PH_NS_G;
    endcase
    return n;
  endfunction

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              locked_q, locked_d;
  logic              err_onehot_q, err_onehot_d;
  logic              err_conflict_q, err_conflict_d;
  logic              err_seq_q, err_seq_d;
  logic              err_dur_q, err_dur_d;
  logic              err_any_q, err_any_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;

  logic              ns_oh, ew_oh;
  logic              dec_valid;
  phase_t            dec_phase;
  logic              legal;
  logic              succ_ok;
  logic              cnt_at_exp;

  // Lamp decode
  always_comb begin
    ns_oh     = (ns_g & ~ns_y & ~ns_r) | (~ns_g & ns_y & ~ns_r) | (~ns_g & ~ns_y & ns_r);
    ew_oh     = (ew_g & ~ew_y & ~ew_r) | (~ew_g & ew_y & ~ew_r) | (~ew_g & ~ew_y & ew_r);
    dec_valid = 1'b1;
    dec_phase = PH_NS_G;
    if (ns_g & ew_r)      dec_phase = PH_NS_G;
    else if (ns_y & ew_r) dec_phase = PH_NS_Y;
    else if (ew_g & ns_r) dec_phase = PH_EW_G;
    else if (ew_y & ns_r) dec_phase = PH_EW_Y;
    else                  dec_valid = 1'b0;
    // All-red is one-hot and conflict-free but still not a phase
    legal = ns_oh & ew_oh & dec_valid;
  end

  // phase_q is the previous legal phase whenever SYNC/TRACK is active,
  // since any illegal sample forces IDLE.
  assign succ_ok    = (dec_phase == next_phase(phase_q));
  assign cnt_at_exp = (tick_cnt_q == exp_ticks(phase_q));

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    tick_cnt_d     = tick_cnt_q;
    locked_d       = locked_q;
    cycle_count_d  = cycle_count_q;
    err_onehot_d   = ~ns_oh | ~ew_oh;
    err_conflict_d = ~ns_r & ~ew_r;
    err_seq_d      = 1'b0;
    err_dur_d      = 1'b0;

    if (legal) begin
      phase_d = dec_phase;
    end

    if (!legal) begin
      state_d    = ST_IDLE;
      locked_d   = 1'b0;
      tick_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_SYNC;
          tick_cnt_d = tick ? TW'(1) : '0;
        end
        default: begin
          if (dec_phase == phase_q) begin
            if (tick) begin
              if (cnt_at_exp) begin
                // Overrun: report once and resynchronise instead of repeating
                err_dur_d  = 1'b1;
                state_d    = ST_IDLE;
                locked_d   = 1'b0;
                tick_cnt_d = '0;
              end else begin
                tick_cnt_d = tick_cnt_q + TW'(1);
              end
            end
          end else begin
            // A tick in the change cycle belongs to the new phase
            tick_cnt_d = tick ? TW'(1) : '0;
            if (state_q == ST_SYNC) begin
              if (succ_ok) begin
                state_d = ST_TRACK;
              end else begin
                err_seq_d = 1'b1;
                state_d   = ST_IDLE;
              end
            end else begin
              err_seq_d = ~succ_ok;
              err_dur_d = ~cnt_at_exp;
              if (succ_ok && cnt_at_exp) begin
                locked_d = 1'b1;
                if ((phase_q == PH_EW_Y) && (cycle_count_q != '1)) begin
                  cycle_count_d = cycle_count_q + CNT_W'(1);
                end
              end else begin
                state_d  = ST_IDLE;
                locked_d = 1'b0;
              end
            end
          end
        end
      endcase
    end

    err_any_d = err_any_q | err_onehot_d | err_conflict_d | err_seq_d | err_dur_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      phase_q        <= PH_NS_G;
      tick_cnt_q     <= '0;
      locked_q       <= 1'b0;
      err_onehot_q   <= 1'b0;
      err_conflict_q <= 1'b0;
      err_seq_q      <= 1'b0;
      err_dur_q      <= 1'b0;
      err_any_q      <= 1'b0;
      cycle_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      tick_cnt_q     <= tick_cnt_d;
      locked_q       <= locked_d;
      err_onehot_q   <= err_onehot_d;
      err_conflict_q <= err_conflict_d;
      err_seq_q      <= err_seq_d;
      err_dur_q      <= err_dur_d;
      err_any_q      <= err_any_d;
      cycle_count_q  <= cycle_count_d;
    end
  end

  assign phase        = phase_q;
  assign locked       = locked_q;
  assign err_onehot   = err_onehot_q;
  assign err_conflict = err_conflict_q;
  assign err_seq      = err_seq_q;
  assign err_dur      = err_dur_q;
  assign err_any      = err_any_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_traffic_light_checker.sv
// Directed bench for traffic_light_checker. A second instance with a 2-bit
// cycle counter shares the stimulus to observe saturation.
module tb_traffic_light_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;

  logic [1:0]  phase, phase_s;
  logic        locked, locked_s;
  logic        err_onehot, err_onehot_s;
  logic        err_conflict, err_conflict_s;
  logic        err_seq, err_seq_s;
  logic        err_dur, err_dur_s;
  logic        err_any, err_any_s;
  logic [15:0] cycle_count;
  logic [1:0]  cycle_count_s;

  int checks   = 0;
  int failures = 0;

  // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
  localparam logic [5:0] L_NSG      = 6'b100_001;
  localparam logic [5:0] L_NSY      = 6'b010_001;
  localparam logic [5:0] L_EWG      = 6'b001_100;
  localparam logic [5:0] L_EWY      = 6'b001_010;
  localparam logic [5:0] L_CONFLICT = 6'b100_100;
  localparam logic [5:0] L_BAD_NS   = 6'b110_001;

  always #5 clk = ~clk;

  traffic_light_checker #(.G_TICKS(5), .Y_TICKS(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .tick(tick),
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r),
    .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
    .phase(phase), .locked(locked),
    .err_onehot(err_onehot), .err_conflict(err_conflict),
    .err_seq(err_seq), .err_dur(err_dur), .err_any(err_any),
    .cycle_count(cycle_count)
  );

  traffic_light_checker #(.G_TICKS(5), .Y_TICKS(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .tick(tick),
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r),
    .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
    .phase(phase_s), .locked(locked_s),
    .err_onehot(err_onehot_s), .err_conflict(err_conflict_s),
    .err_seq(err_seq_s), .err_dur(err_dur_s), .err_any(err_any_s),
    .cycle_count(cycle_count_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive lamps and tick, outputs are sampled 1ns after the edge
  task automatic cyc(input logic [5:0] l, input logic t);
    {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = l;
    tick = t;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] lamp_of(input logic [1:0] p);
    case (p)
      2'd0:    return L_NSG;
      2'd1:    return L_NSY;
      2'd2:    return L_EWG;
      default: return L_EWY;
    endcase
  endfunction

  // Enter phase p, check the decoded phase, then deliver n ticks
  task automatic run_phase(input logic [1:0] p, input int n);
    cyc(lamp_of(p), 1'b0);
    check_eq("phase_step", {30'd0, phase}, {30'd0, p});
    for (int i = 0; i < n; i++) begin
      cyc(lamp_of(p), 1'b1);
      cyc(lamp_of(p), 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_phase"}, {30'd0, phase}, 32'd0);
    check_eq({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check_eq({tag, "_errs"}, {27'd0, err_onehot, err_conflict, err_seq, err_dur, err_any}, 32'd0);
    check_eq({tag, "_count"}, {16'd0, cycle_count}, 32'd0);
  endtask

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = L_NSG;
    cyc(L_NSG, 1'b0);
    cyc(L_NSG, 1'b1);
    check_all_zero("reset");
    rst = 1'b0;

    // Nominal: partial start in NS_G, then five completed cycles
    run_phase(2'd0, 5);
    run_phase(2'd1, 2);
    check_eq("sync_no_lock", {31'd0, locked}, 32'd0);
    run_phase(2'd2, 5);
    check_eq("first_lock", {31'd0, locked}, 32'd1);
    run_phase(2'd3, 2);
    for (int c = 0; c < 4; c++) begin
      run_phase(2'd0, 5);
      run_phase(2'd1, 2);
      run_phase(2'd2, 5);
      run_phase(2'd3, 2);
    end
    run_phase(2'd0, 5);
    check_eq("nominal_count", {16'd0, cycle_count}, 32'd5);
    check_eq("sat_count", {30'd0, cycle_count_s}, 32'd3);
    check_eq("nominal_locked", {31'd0, locked}, 32'd1);
    check_eq("nominal_err_any", {31'd0, err_any}, 32'd0);

    // Overrun: sixth tick in a tracked NS_G
    cyc(L_NSG, 1'b1);
    check_eq("overrun_dur", {31'd0, err_dur}, 32'd1);
    check_eq("overrun_seq", {31'd0, err_seq}, 32'd0);
    check_eq("overrun_locked", {31'd0, locked}, 32'd0);
    check_eq("overrun_any", {31'd0, err_any}, 32'd1);
    cyc(L_NSG, 1'b1);
    check_eq("overrun_once", {31'd0, err_dur}, 32'd0);
    run_phase(2'd1, 2);
    run_phase(2'd2, 5);
    check_eq("relock_after_dur", {31'd0, locked}, 32'd1);

    // Conflict: both greens lit, both reds off
    cyc(L_CONFLICT, 1'b0);
    check_eq("conflict_pulse", {31'd0, err_conflict}, 32'd1);
    check_eq("conflict_onehot", {31'd0, err_onehot}, 32'd0);
    check_eq("conflict_locked", {31'd0, locked}, 32'd0);
    check_eq("conflict_phase_hold", {30'd0, phase}, 32'd2);
    check_eq("conflict_any", {31'd0, err_any}, 32'd1);
    cyc(L_EWG, 1'b0);
    check_eq("conflict_1cycle", {31'd0, err_conflict}, 32'd0);
    run_phase(2'd2, 5);
    run_phase(2'd3, 2);
    run_phase(2'd0, 5);
    check_eq("relock_after_conflict", {31'd0, locked}, 32'd1);
    check_eq("any_sticky", {31'd0, err_any}, 32'd1);

    // Sequence skip: NS_G straight to EW_G after a full 5 ticks
    cyc(L_EWG, 1'b0);
    check_eq("skip_seq", {31'd0, err_seq}, 32'd1);
    check_eq("skip_dur", {31'd0, err_dur}, 32'd0);
    check_eq("skip_locked", {31'd0, locked}, 32'd0);
    cyc(L_EWG, 1'b0);
    check_eq("skip_1cycle", {31'd0, err_seq}, 32'd0);

    // Short yellow: NS_Y for one tick then EW_G
    run_phase(2'd2, 5);
    run_phase(2'd3, 2);
    run_phase(2'd0, 5);
    check_eq("relock_after_skip", {31'd0, locked}, 32'd1);
    run_phase(2'd1, 1);
    cyc(L_EWG, 1'b0);
    check_eq("short_dur", {31'd0, err_dur}, 32'd1);
    check_eq("short_seq", {31'd0, err_seq}, 32'd0);
    check_eq("short_locked", {31'd0, locked}, 32'd0);

    // Two NS lamps lit
    cyc(L_BAD_NS, 1'b0);
    check_eq("onehot_pulse", {31'd0, err_onehot}, 32'd1);
    check_eq("onehot_conflict", {31'd0, err_conflict}, 32'd0);

    // Reset in the middle of EW_Y with err_any set
    run_phase(2'd3, 1);
    check_eq("pre_reset_any", {31'd0, err_any}, 32'd1);
    rst = 1'b1;
    cyc(L_EWY, 1'b0);
    check_all_zero("mid_reset");
    rst = 1'b0;
    cyc(L_EWY, 1'b0);
    check_eq("post_reset_phase", {30'd0, phase}, 32'd3);
    cyc(L_NSG, 1'b0);
    check_eq("partial_no_dur", {31'd0, err_dur}, 32'd0);
    check_eq("partial_no_seq", {31'd0, err_seq}, 32'd0);
    check_eq("partial_any", {31'd0, err_any}, 32'd0);
    check_eq("partial_phase", {30'd0, phase}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
